mem_bus_arbiter: RTL and testbench

Shares one unified single-port memory bus between the CPU's instruction-fetch port and its data port.
Sequences each access and buffers the returned words. Generates the 6-bit pipeline stall_ctrl vector, merging in the ID-stage stall request.
Sits between mips_cpu and the memory model at the SoC top.

---
 rtl/mem_bus_arbiter_pkg.sv | 20 ++
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the unified memory-bus arbiter: FSM encoding,
// pipeline stall vectors and the word returned on a bus timeout.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_D_WAIT = 2'd1,
    ST_I_WAIT = 2'd2
  } arb_state_t;

  // stall_ctrl bits: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
  localparam logic [5:0] STALL_NONE  = 6'b000000;
  localparam logic [5:0] STALL_ID    = 6'b000111;
  localparam logic [5:0] STALL_IF    = 6'b000011;
  localparam logic [5:0] STALL_IF_ID = 6'b000111;
  localparam logic [5:0] STALL_MEM   = 6'b011111;

  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one single-port memory bus,
// buffers returned words and drives the pipeline stall vector.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              id_stall_req,
  output logic [5:0]        stall_ctrl,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);

  arb_state_t        r_state;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic              r_bus_err;
  logic              r_ibuf_valid;
  logic [ADDR_W-1:0] r_ibuf_addr;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_dbuf_valid;
  logic [DATA_W-1:0] r_dm_rdata;
  logic [7:0]        r_wait_cnt;

  logic              w_ihit;
  logic              w_need_d;
  logic              w_need_i;
  logic              w_timeout;
  logic [5:0]        w_stall;

  assign w_ihit    = r_ibuf_valid && (r_ibuf_addr == if_addr);
  assign w_need_d  = dm_req && !r_dbuf_valid;
  assign w_need_i  = if_req && !w_ihit;
  // Abort on the edge that would take the wait count to TIMEOUT
  assign w_timeout = (r_wait_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    w_stall = STALL_NONE;
    if (reset)             w_stall = STALL_NONE;
    else if (w_need_d)     w_stall = STALL_MEM;
    else if (w_need_i)     w_stall = id_stall_req ? STALL_IF_ID : STALL_IF;
    else if (id_stall_req) w_stall = STALL_ID;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_bus_err    <= 1'b0;
      r_ibuf_valid <= 1'b0;
      r_ibuf_addr  <= '0;
      r_if_rdata   <= '0;
      r_dbuf_valid <= 1'b0;
      r_dm_rdata   <= '0;
      r_wait_cnt   <= '0;
    end else begin
      // A stage that advances consumes its buffered word; fills below never collide
      if (!w_stall[1]) r_ibuf_valid <= 1'b0;
      if (!w_stall[4]) r_dbuf_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_wait_cnt <= '0;
          if (w_need_d) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= dm_we;
            r_bus_addr  <= dm_addr;
            r_bus_wdata <= dm_wdata;
            r_state     <= ST_D_WAIT;
          end else if (w_need_i) begin
            r_bus_req  <= 1'b1;
            r_bus_we   <= 1'b0;
            r_bus_addr <= if_addr;
            r_state    <= ST_I_WAIT;
          end
        end
        ST_D_WAIT: begin
          if (bus_ack || w_timeout) begin
            if (!r_bus_we) r_dm_rdata <= bus_ack ? bus_rdata : DATA_W'(ERR_WORD);
            if (!bus_ack)  r_bus_err  <= 1'b1;
            r_dbuf_valid <= 1'b1;
            r_bus_req    <= 1'b0;
            r_wait_cnt   <= '0;
            r_state      <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        ST_I_WAIT: begin
          if (bus_ack || w_timeout) begin
            r_if_rdata   <= bus_ack ? bus_rdata : DATA_W'(ERR_WORD);
            if (!bus_ack) r_bus_err <= 1'b1;
            r_ibuf_addr  <= r_bus_addr;
            r_ibuf_valid <= 1'b1;
            r_bus_req    <= 1'b0;
            r_wait_cnt   <= '0;
            r_state      <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stall_ctrl = w_stall;
  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_err    = r_bus_err;
  assign if_rdata   = r_if_rdata;
  assign dm_rdata   = r_dm_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter with a one-cycle-ack memory model
// and a scoreboard of expected bus transactions and returned words.
module tb_mem_bus_arbiter;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_ID   = 6'b000111;
  localparam logic [5:0] S_IF   = 6'b000011;
  localparam logic [5:0] S_MEM  = 6'b011111;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        id_stall_req = 1'b0;
  logic [5:0]  stall_ctrl;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        bus_err;

  logic        mem_en = 1'b1;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  txn_t        txq[$];
  logic [31:0] rdq[$];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .id_stall_req(id_stall_req), .stall_ctrl(stall_ctrl),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2401_0005;
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  // Memory: acks one cycle after it first sees bus_req high
  always @(posedge clk) begin
    bus_ack   <= mem_en && (bus_req === 1'b1) && !bus_ack;
    bus_rdata <= mem_word(bus_addr);
  end

  // Bus monitor: each new request is popped against the expected-transaction queue
  logic        mon_prev = 1'b0;
  txn_t        mon_cur;
  always @(negedge clk) begin
    if (bus_req === 1'b1 && !mon_prev) begin
      total_cnt++;
      if (txq.size() == 0) begin
        $display("FAIL bus_txn_unexpected: got we=%b addr=%h, required none", bus_we, bus_addr);
      end else begin
        mon_cur = txq.pop_front();
        if (bus_we !== mon_cur.we || bus_addr !== mon_cur.addr ||
            (mon_cur.we && bus_wdata !== mon_cur.wdata))
          $display("FAIL bus_txn: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                   bus_we, bus_addr, bus_wdata, mon_cur.we, mon_cur.addr, mon_cur.wdata);
        else pass_cnt++;
      end
    end else if (bus_req === 1'b1 && mon_prev) begin
      total_cnt++;
      if (bus_we !== mon_cur.we || bus_addr !== mon_cur.addr ||
          (mon_cur.we && bus_wdata !== mon_cur.wdata))
        $display("FAIL bus_stable: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                 bus_we, bus_addr, bus_wdata, mon_cur.we, mon_cur.addr, mon_cur.wdata);
      else pass_cnt++;
    end
    mon_prev = (bus_req === 1'b1);
  end

  // Waits (bounded) for stall_ctrl[idx] to clear, counting cycles whose stall equals cnt_val
  task automatic wait_release(input int idx, input logic [5:0] cnt_val, input int limit,
                              output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (stall_ctrl[idx] === 1'b0) begin
        ok = 1'b1;
        break;
      end
      if (stall_ctrl === cnt_val) cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    if_req = 1'b1;
    dm_req = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (stall_ctrl !== S_NONE) $display("FAIL reset_stall: got %b, required %b", stall_ctrl, S_NONE);
    else pass_cnt++;
    total_cnt++;
    if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_err !== 1'b0)
      $display("FAIL reset_bus_ctl: got req=%b we=%b err=%b, required 0 0 0", bus_req, bus_we, bus_err);
    else pass_cnt++;
    total_cnt++;
    if (bus_addr !== '0 || bus_wdata !== '0)
      $display("FAIL reset_bus_data: got addr=%h wdata=%h, required 0 0", bus_addr, bus_wdata);
    else pass_cnt++;
    total_cnt++;
    if (if_rdata !== '0 || dm_rdata !== '0)
      $display("FAIL reset_rdata: got if=%h dm=%h, required 0 0", if_rdata, dm_rdata);
    else pass_cnt++;
    if_req = 1'b0;
    dm_req = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    int cyc;
    bit ok;
    logic [31:0] exp;
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    txq.push_back('{1'b0, 32'h0000_0040, 32'h0});
    rdq.push_back(32'h2401_0005);
    #1;
    wait_release(1, S_IF, 20, cyc, ok);
    total_cnt++;
    if (!ok || cyc != 3) $display("FAIL fetch_stall_cycles: got %0d (released=%0b), required 3", cyc, ok);
    else pass_cnt++;
    exp = rdq.pop_front();
    total_cnt++;
    if (if_rdata !== exp) $display("FAIL fetch_rdata: got %h, required %h", if_rdata, exp);
    else pass_cnt++;
    total_cnt++;
    if (stall_ctrl !== S_NONE) $display("FAIL fetch_stall_after: got %b, required %b", stall_ctrl, S_NONE);
    else pass_cnt++;
  endtask

  task automatic test_load_fetch();
    int cyc;
    bit ok;
    logic [31:0] exp;
    if_addr = 32'h0000_0044;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0000_0100;
    txq.push_back('{1'b0, 32'h0000_0100, 32'h0});
    txq.push_back('{1'b0, 32'h0000_0044, 32'h0});
    rdq.push_back(mem_word(32'h0000_0100));
    rdq.push_back(mem_word(32'h0000_0044));
    #1;
    wait_release(4, S_MEM, 20, cyc, ok);
    total_cnt++;
    if (!ok || cyc != 3) $display("FAIL load_stall_cycles: got %0d (released=%0b), required 3", cyc, ok);
    else pass_cnt++;
    exp = rdq.pop_front();
    total_cnt++;
    if (dm_rdata !== exp) $display("FAIL load_rdata: got %h, required %h", dm_rdata, exp);
    else pass_cnt++;
    total_cnt++;
    if (stall_ctrl !== S_IF) $display("FAIL load_then_fetch_stall: got %b, required %b", stall_ctrl, S_IF);
    else pass_cnt++;
    dm_req = 1'b0;
    #1;
    wait_release(1, S_IF, 20, cyc, ok);
    total_cnt++;
    if (!ok || cyc != 3) $display("FAIL fetch2_stall_cycles: got %0d (released=%0b), required 3", cyc, ok);
    else pass_cnt++;
    exp = rdq.pop_front();
    total_cnt++;
    if (if_rdata !== exp) $display("FAIL fetch2_rdata: got %h, required %h", if_rdata, exp);
    else pass_cnt++;
  endtask

  task automatic test_store();
    int cyc;
    bit ok;
    logic [31:0] old_d;
    old_d    = dm_rdata;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h0000_0200;
    dm_wdata = 32'h1234_5678;
    txq.push_back('{1'b1, 32'h0000_0200, 32'h1234_5678});
    #1;
    wait_release(4, S_MEM, 20, cyc, ok);
    total_cnt++;
    if (!ok || cyc != 3) $display("FAIL store_stall_cycles: got %0d (released=%0b), required 3", cyc, ok);
    else pass_cnt++;
    total_cnt++;
    if (dm_rdata !== old_d) $display("FAIL store_dm_rdata: got %h, required %h", dm_rdata, old_d);
    else pass_cnt++;
    total_cnt++;
    if (stall_ctrl !== S_NONE || txq.size() != 0)
      $display("FAIL store_no_refetch: got stall=%b pending=%0d, required %b 0", stall_ctrl, txq.size(), S_NONE);
    else pass_cnt++;
  endtask

  task automatic test_id_stall();
    dm_req       = 1'b0;
    dm_we        = 1'b0;
    id_stall_req = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (stall_ctrl !== S_ID || bus_req !== 1'b0)
        $display("FAIL id_stall: got stall=%b req=%b, required %b 0", stall_ctrl, bus_req, S_ID);
      else pass_cnt++;
      @(negedge clk);
    end
    id_stall_req = 1'b0;
    #1;
    total_cnt++;
    if (stall_ctrl !== S_NONE) $display("FAIL id_stall_ibuf_kept: got %b, required %b", stall_ctrl, S_NONE);
    else pass_cnt++;
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_redirect();
    int cyc;
    bit redirected;
    logic [31:0] exp;
    cyc = 0;
    redirected = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0000_0044;
    txq.push_back('{1'b0, 32'h0000_0044, 32'h0});
    txq.push_back('{1'b0, 32'h0000_0080, 32'h0});
    rdq.push_back(mem_word(32'h0000_0080));
    #1;
    for (int i = 0; i < 30; i++) begin
      if (stall_ctrl[1] === 1'b0) break;
      if (stall_ctrl === S_IF) cyc++;
      if (bus_req === 1'b1 && !redirected) begin
        if_addr = 32'h0000_0080;
        redirected = 1'b1;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (cyc != 6 || stall_ctrl[1] !== 1'b0)
      $display("FAIL redirect_stall_cycles: got %0d (stall=%b), required 6", cyc, stall_ctrl);
    else pass_cnt++;
    exp = rdq.pop_front();
    total_cnt++;
    if (if_rdata !== exp) $display("FAIL redirect_rdata: got %h, required %h", if_rdata, exp);
    else pass_cnt++;
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int req_cyc;
    bit ok;
    int dummy;
    logic [31:0] exp;
    req_cyc = 0;
    mem_en  = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0000_0300;
    txq.push_back('{1'b0, 32'h0000_0300, 32'h0});
    rdq.push_back(32'hDEAD_BEEF);
    #1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (stall_ctrl[1] === 1'b0) begin
        ok = 1'b1;
        break;
      end
      if (bus_req === 1'b1) req_cyc++;
      @(negedge clk);
    end
    dummy = 0;
    total_cnt++;
    if (!ok || req_cyc != 4) $display("FAIL timeout_req_cycles: got %0d (released=%0b), required 4", req_cyc, ok);
    else pass_cnt++;
    total_cnt++;
    if (bus_err !== 1'b1 || bus_req !== 1'b0)
      $display("FAIL timeout_err: got err=%b req=%b, required 1 0", bus_err, bus_req);
    else pass_cnt++;
    exp = rdq.pop_front();
    total_cnt++;
    if (if_rdata !== exp) $display("FAIL timeout_rdata: got %h, required %h", if_rdata, exp);
    else pass_cnt++;
    if_req = 1'b0;
    mem_en = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (bus_err !== 1'b1) $display("FAIL timeout_err_sticky: got %b, required 1", bus_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_access();
    bit seen;
    seen    = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    txq.push_back('{1'b0, 32'h0000_0040, 32'h0});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (!seen) $display("FAIL midreset_issue: got no bus_req, required bus_req=1");
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (stall_ctrl !== S_NONE || bus_req !== 1'b0 || bus_err !== 1'b0)
      $display("FAIL midreset_clear: got stall=%b req=%b err=%b, required %b 0 0",
               stall_ctrl, bus_req, bus_err, S_NONE);
    else pass_cnt++;
    reset  = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (if_rdata !== '0 || dm_rdata !== '0 || bus_req !== 1'b0)
      $display("FAIL late_ack_ignored: got if=%h dm=%h req=%b, required 0 0 0", if_rdata, dm_rdata, bus_req);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load_fetch();
    test_store();
    test_id_stall();
    test_redirect();
    test_timeout();
    test_reset_mid_access();
    repeat (2) @(negedge clk);
    total_cnt++;
    if (txq.size() != 0 || rdq.size() != 0)
      $display("FAIL scoreboard_drained: got txq=%0d rdq=%0d, required 0 0", txq.size(), rdq.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit reached, required bench completion");
    $fatal(1);
  end

endmodule
